axis_uart_arbiter: RTL

AXIS_UART_ARBITER -- requirements
Module: axis_uart_arbiter

---
 rtl/axis_uart_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axis_uart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_uart_arbiter
//  Description : Four-source round-robin AXI-Stream packet arbiter feeding a
//                single UART transmitter stream. One arbitration cycle per
//                grant, zero-latency beat path, forced packet termination
//                after MAX_PKT beats and an optional inter-packet idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_uart_arbiter #(
    parameter int DATA_BITS  = 8,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_PKT    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*DATA_BITS-1:0] s_tdata,
    input  logic [3:0]             s_tvalid,
    input  logic [3:0]             s_tlast,
    output logic [3:0]             s_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic                   enable,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   trunc_err
);

    // Beat counter only has to reach MAX_PKT-1; gap counter only GAP_CYCLES-1.
    localparam int c_BW = (MAX_PKT > 2) ? $clog2(MAX_PKT) : 1;
    localparam int c_GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_BW-1:0] c_BEAT_LAST = c_BW'(MAX_PKT - 1);
    localparam logic [c_BW-1:0] c_BEAT_ONE  = c_BW'(1);
    localparam logic [c_GW-1:0] c_GAP_LOAD  = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_GW-1:0] c_GAP_ONE   = c_GW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_grant_id;
    logic [1:0]             r_last_grant;
    logic [c_BW-1:0]        r_beat_cnt;
    logic [c_GW-1:0]        r_gap_cnt;
    logic                   r_trunc_err;

    logic [DATA_BITS-1:0]   w_src_data [4];
    logic [1:0]             w_arb_id;
    logic [1:0]             w_scan_idx;
    logic                   w_arb_hit;
    logic                   w_force_last;
    logic                   w_xfer;

    // Split the flat source data bus into one word per source.
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_src_data[gi] = s_tdata[gi*DATA_BITS +: DATA_BITS];
    end

    // Round-robin pick: scan last_grant+4 down to +1 so the nearest
    // successor of the previous winner overwrites the others.
    always_comb begin
        w_arb_hit  = 1'b0;
        w_arb_id   = r_last_grant;
        w_scan_idx = r_last_grant;
        for (int k = 4; k >= 1; k--) begin
            w_scan_idx = r_last_grant + 2'(k);
            if (s_tvalid[w_scan_idx]) begin
                w_arb_hit = 1'b1;
                w_arb_id  = w_scan_idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the zero-latency stream path of the granted source.
    always_comb begin
        w_state_nxt  = r_state;
        m_tdata      = '0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        s_tready     = 4'b0000;
        w_force_last = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_arb_hit) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                m_tdata              = w_src_data[r_grant_id];
                m_tvalid             = s_tvalid[r_grant_id];
                w_force_last         = s_tvalid[r_grant_id] && (r_beat_cnt == c_BEAT_LAST);
                m_tlast              = s_tlast[r_grant_id] | w_force_last;
                s_tready[r_grant_id] = m_tready;
                w_xfer               = s_tvalid[r_grant_id] & m_tready;
                if (w_xfer && m_tlast) begin
                    w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, beat/gap counting and the sticky truncation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id   <= 2'd0;
            r_last_grant <= 2'd3;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_trunc_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_arb_hit) begin
                        r_grant_id <= w_arb_id;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                        if (w_force_last) begin
                            r_trunc_err <= 1'b1;
                        end
                        if (m_tlast) begin
                            r_last_grant <= r_grant_id;
                            r_gap_cnt    <= c_GAP_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign grant_id  = r_grant_id;
    assign busy      = (r_state != ST_IDLE);
    assign trunc_err = r_trunc_err;

endmodule
`default_nettype wire
